// File: rtl/gsu_pkg.sv
// Shared definitions for the GSU bus responder: FSM state encoding,
// default address-map constants and the access timeout limit.
package gsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROM_ACC = 2'd1,
    ST_RAM_ACC = 2'd2,
    ST_DONE    = 2'd3
  } gsu_state_e;

  localparam logic [23:0] RAM_BASE_DEF = 24'hE00000;
  localparam logic [23:0] RAM_MASK_DEF = 24'h01FFFF;
  localparam logic [23:0] ROM_MASK_DEF = 24'h1FFFFF;

  // Cycles an access may wait for MEM_ACK before it is abandoned.
  localparam logic [7:0]  TMO_LIMIT    = 8'd255;
  // Read data returned for an abandoned access.
  localparam logic [7:0]  TMO_DATA     = 8'hFF;

endpackage

// File: rtl/gsu_bus_slot.sv
// One-deep pending request slot for a single GSU bus port.
// A request pulse is visible on the outputs in the same cycle it arrives,
// so the arbiter can issue it without first waiting for the slot register.
// A newer pulse always replaces an older un-issued one; a write pulse
// coincident with a read pulse wins.
module gsu_bus_slot
  import gsu_pkg::*;
(
  input  logic        clkin,
  input  logic        nrst,
  input  logic        i_rrq,
  input  logic        i_wrq,
  input  logic [23:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_issue,
  output logic        o_pend,
  output logic        o_wr,
  output logic [23:0] o_addr,
  output logic [7:0]  o_data
);

  logic        r_pend;
  logic        r_wr;
  logic [23:0] r_addr;
  logic [7:0]  r_data;
  logic        w_new;

  assign w_new  = i_rrq | i_wrq;
  assign o_pend = r_pend | w_new;
  assign o_wr   = w_new ? i_wrq  : r_wr;
  assign o_addr = w_new ? i_addr : r_addr;
  assign o_data = w_new ? i_data : r_data;

  // Latch or overwrite the slot on a pulse; clear it when the arbiter issues it.
  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      r_pend <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_issue) begin
      r_pend <= 1'b0;
    end else if (w_new) begin
      r_pend <= 1'b1;
      r_wr   <= i_wrq;
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/gsu_bus_responder.sv
// GSU bus responder: arbitrates the GSU ROM and RAM request ports onto one
// shared external memory port, with round-robin between contending ports.
// Optional feature macro: GSU_BUS_TIMEOUT_EN -- abandons an access after
// TMO_LIMIT cycles without MEM_ACK, returns 8'hFF and sets sticky bus_err.
module gsu_bus_responder
  import gsu_pkg::*;
#(
  parameter logic [23:0] RAM_BASE = RAM_BASE_DEF,
  parameter logic [23:0] RAM_MASK = RAM_MASK_DEF,
  parameter logic [23:0] ROM_MASK = ROM_MASK_DEF
) (
  input  logic        clkin,
  input  logic        nrst,
  input  logic [23:0] ROM_BUS_ADDR,
  input  logic        ROM_BUS_RRQ,
  output logic [7:0]  ROM_BUS_DI,
  output logic        ROM_BUS_RDY,
  input  logic [23:0] RAM_BUS_ADDR,
  input  logic        RAM_BUS_RRQ,
  input  logic        RAM_BUS_WRQ,
  input  logic [7:0]  RAM_BUS_DO,
  output logic [7:0]  RAM_BUS_DI,
  output logic        RAM_BUS_RDY,
  input  logic        ron,
  input  logic        ran,
  output logic [23:0] MEM_ADDR,
  output logic [7:0]  MEM_DO,
  output logic        MEM_RD,
  output logic        MEM_WR,
  input  logic [7:0]  MEM_DI,
  input  logic        MEM_ACK,
  output logic        bus_err
);

  gsu_state_e  r_state;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [23:0] r_mem_addr;
  logic [7:0]  r_mem_do;
  logic [7:0]  r_rom_di;
  logic [7:0]  r_ram_di;
  logic        r_rom_rdy;
  logic        r_ram_rdy;
  logic        r_prefer_ram;

  logic        w_rom_pend;
  logic        w_rom_wr;
  logic [23:0] w_rom_addr;
  logic [7:0]  w_rom_data;
  logic        w_ram_pend;
  logic        w_ram_wr;
  logic [23:0] w_ram_addr;
  logic [7:0]  w_ram_data;
  logic        w_rom_ok;
  logic        w_ram_ok;
  logic        w_grant_rom;
  logic        w_grant_ram;
  logic        w_rom_issue;
  logic        w_ram_issue;
  logic        w_in_acc;
  logic        w_tmo;
  logic [7:0]  w_rd_data;

  gsu_bus_slot u_rom_slot (
    .clkin   (clkin),
    .nrst    (nrst),
    .i_rrq   (ROM_BUS_RRQ),
    .i_wrq   (1'b0),
    .i_addr  (ROM_BUS_ADDR),
    .i_data  (8'h00),
    .i_issue (w_rom_issue),
    .o_pend  (w_rom_pend),
    .o_wr    (w_rom_wr),
    .o_addr  (w_rom_addr),
    .o_data  (w_rom_data)
  );

  gsu_bus_slot u_ram_slot (
    .clkin   (clkin),
    .nrst    (nrst),
    .i_rrq   (RAM_BUS_RRQ),
    .i_wrq   (RAM_BUS_WRQ),
    .i_addr  (RAM_BUS_ADDR),
    .i_data  (RAM_BUS_DO),
    .i_issue (w_ram_issue),
    .o_pend  (w_ram_pend),
    .o_wr    (w_ram_wr),
    .o_addr  (w_ram_addr),
    .o_data  (w_ram_data)
  );

  // A port is eligible only while the GSU owns its bus; un-owned requests wait.
  assign w_rom_ok    = w_rom_pend & ron;
  assign w_ram_ok    = w_ram_pend & ran;
  assign w_grant_ram = w_ram_ok & (~w_rom_ok | r_prefer_ram);
  assign w_grant_rom = w_rom_ok & ~w_grant_ram;
  assign w_rom_issue = (r_state == ST_IDLE) & w_grant_rom;
  assign w_ram_issue = (r_state == ST_IDLE) & w_grant_ram;
  assign w_in_acc    = (r_state == ST_ROM_ACC) | (r_state == ST_RAM_ACC);
  assign w_rd_data   = MEM_ACK ? MEM_DI : TMO_DATA;

`ifdef GSU_BUS_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_bus_err;

  assign w_tmo   = w_in_acc & (r_tmo_cnt == 8'd0);
  assign bus_err = r_bus_err;

  // Down-counter armed at issue; reaching zero without MEM_ACK abandons the access.
  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      r_tmo_cnt <= 8'd0;
      r_bus_err <= 1'b0;
    end else if (w_rom_issue | w_ram_issue) begin
      r_tmo_cnt <= TMO_LIMIT - 8'd1;
    end else if (w_in_acc && !MEM_ACK) begin
      if (r_tmo_cnt == 8'd0) r_bus_err <= 1'b1;
      else                   r_tmo_cnt <= r_tmo_cnt - 8'd1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Access sequencer: issue, hold strobe until ACK, pulse RDY, return to idle.
  // The round-robin pointer moves only when both ports contended.
  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_do     <= '0;
      r_rom_di     <= '0;
      r_ram_di     <= '0;
      r_rom_rdy    <= 1'b0;
      r_ram_rdy    <= 1'b0;
      r_prefer_ram <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ram) begin
            r_state    <= ST_RAM_ACC;
            r_mem_rd   <= ~w_ram_wr;
            r_mem_wr   <= w_ram_wr;
            r_mem_addr <= RAM_BASE + (w_ram_addr & RAM_MASK);
            r_mem_do   <= w_ram_data;
            if (w_rom_ok) r_prefer_ram <= 1'b0;
          end else if (w_grant_rom) begin
            r_state    <= ST_ROM_ACC;
            r_mem_rd   <= ~w_rom_wr;
            r_mem_wr   <= w_rom_wr;
            r_mem_addr <= w_rom_addr & ROM_MASK;
            r_mem_do   <= w_rom_data;
            if (w_ram_ok) r_prefer_ram <= 1'b1;
          end
        end
        ST_ROM_ACC, ST_RAM_ACC: begin
          if (MEM_ACK || w_tmo) begin
            r_state  <= ST_DONE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_state == ST_RAM_ACC) begin
              r_ram_rdy <= 1'b1;
              if (r_mem_rd) r_ram_di <= w_rd_data;
            end else begin
              r_rom_rdy <= 1'b1;
              if (r_mem_rd) r_rom_di <= w_rd_data;
            end
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_rom_rdy <= 1'b0;
          r_ram_rdy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MEM_RD      = r_mem_rd;
  assign MEM_WR      = r_mem_wr;
  assign MEM_ADDR    = r_mem_addr;
  assign MEM_DO      = r_mem_do;
  assign ROM_BUS_DI  = r_rom_di;
  assign RAM_BUS_DI  = r_ram_di;
  assign ROM_BUS_RDY = r_rom_rdy;
  assign RAM_BUS_RDY = r_ram_rdy;

endmodule

// File: tb/tb_gsu_bus_responder.sv
// Self-checking bench for gsu_bus_responder. Expected memory accesses and
// expected per-port read data are queued when stimulus is driven and checked
// when the DUT presents the access or its RDY pulse.
module tb_gsu_bus_responder;

  localparam logic [23:0] TB_RAM_BASE = 24'hE00000;
  localparam logic [23:0] TB_RAM_MASK = 24'h01FFFF;
  localparam logic [23:0] TB_ROM_MASK = 24'h1FFFFF;

  logic        clkin;
  logic        nrst;
  logic [23:0] ROM_BUS_ADDR;
  logic        ROM_BUS_RRQ;
  logic [7:0]  ROM_BUS_DI;
  logic        ROM_BUS_RDY;
  logic [23:0] RAM_BUS_ADDR;
  logic        RAM_BUS_RRQ;
  logic        RAM_BUS_WRQ;
  logic [7:0]  RAM_BUS_DO;
  logic [7:0]  RAM_BUS_DI;
  logic        RAM_BUS_RDY;
  logic        ron;
  logic        ran;
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_DO;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [7:0]  MEM_DI;
  logic        MEM_ACK;
  logic        bus_err;

  gsu_bus_responder dut (
    .clkin        (clkin),
    .nrst         (nrst),
    .ROM_BUS_ADDR (ROM_BUS_ADDR),
    .ROM_BUS_RRQ  (ROM_BUS_RRQ),
    .ROM_BUS_DI   (ROM_BUS_DI),
    .ROM_BUS_RDY  (ROM_BUS_RDY),
    .RAM_BUS_ADDR (RAM_BUS_ADDR),
    .RAM_BUS_RRQ  (RAM_BUS_RRQ),
    .RAM_BUS_WRQ  (RAM_BUS_WRQ),
    .RAM_BUS_DO   (RAM_BUS_DO),
    .RAM_BUS_DI   (RAM_BUS_DI),
    .RAM_BUS_RDY  (RAM_BUS_RDY),
    .ron          (ron),
    .ran          (ran),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_DO       (MEM_DO),
    .MEM_RD       (MEM_RD),
    .MEM_WR       (MEM_WR),
    .MEM_DI       (MEM_DI),
    .MEM_ACK      (MEM_ACK),
    .bus_err      (bus_err)
  );

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
  } mem_exp_t;

  mem_exp_t   q_mem[$];
  logic [7:0] q_rom[$];
  logic [7:0] q_ram[$];

  int         checks = 0;
  int         errors = 0;
  int         rom_rdy_cnt = 0;
  int         ram_rdy_cnt = 0;
  logic [7:0] ram_di_model = 8'h00;
  bit         ack_en = 1'b1;
  int         ack_dly = 0;

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  function automatic logic [7:0] mem_data(input logic [23:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  function automatic void exp_rom(input logic [23:0] a);
    logic [23:0] m;
    m = a & TB_ROM_MASK;
    q_mem.push_back({1'b0, m, 8'h00});
    q_rom.push_back(mem_data(m));
  endfunction

  function automatic void exp_ram(input logic [23:0] a, input logic wr, input logic [7:0] d);
    logic [23:0] m;
    m = TB_RAM_BASE + (a & TB_RAM_MASK);
    q_mem.push_back({wr, m, d});
    if (!wr) ram_di_model = mem_data(m);
    q_ram.push_back(ram_di_model);
  endfunction

  // External memory model: checks each new access against the expected
  // queue and acknowledges it after ack_dly extra cycles.
  initial begin
    bit       in_acc;
    int       acc_cyc;
    mem_exp_t e;
    in_acc  = 1'b0;
    acc_cyc = 0;
    MEM_ACK = 1'b0;
    MEM_DI  = 8'h00;
    forever begin
      @(negedge clkin);
      MEM_ACK = 1'b0;
      if (MEM_RD && MEM_WR) begin
        checks++;
        errors++;
        $display("FAIL rd_wr_exclusive: MEM_RD=%b MEM_WR=%b, required not both 1", MEM_RD, MEM_WR);
      end
      if (MEM_RD || MEM_WR) begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          acc_cyc = 0;
          checks++;
          if (q_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_access: unexpected access wr=%b addr=%h", MEM_WR, MEM_ADDR);
          end else begin
            e = q_mem.pop_front();
            if (MEM_WR !== e.wr || MEM_ADDR !== e.addr || (e.wr && MEM_DO !== e.data)) begin
              errors++;
              $display("FAIL mem_access: got wr=%b addr=%h do=%h, required wr=%b addr=%h do=%h",
                       MEM_WR, MEM_ADDR, MEM_DO, e.wr, e.addr, e.data);
            end
          end
        end
        if (ack_en && acc_cyc == ack_dly) begin
          MEM_ACK = 1'b1;
          MEM_DI  = mem_data(MEM_ADDR);
        end
        acc_cyc++;
      end else begin
        in_acc = 1'b0;
      end
    end
  end

  // RDY monitor: pops expected read data per port and checks single-cycle pulses.
  initial begin
    logic       prev_rom;
    logic       prev_ram;
    logic [7:0] ev;
    prev_rom = 1'b0;
    prev_ram = 1'b0;
    forever begin
      @(negedge clkin);
      if (ROM_BUS_RDY) begin
        rom_rdy_cnt++;
        checks++;
        if (prev_rom) begin
          errors++;
          $display("FAIL rom_rdy_width: ROM_BUS_RDY high 2 cycles, required 1");
        end else if (q_rom.size() == 0) begin
          errors++;
          $display("FAIL rom_rdy: unexpected ROM_BUS_RDY, DI=%h", ROM_BUS_DI);
        end else begin
          ev = q_rom.pop_front();
          if (ROM_BUS_DI !== ev) begin
            errors++;
            $display("FAIL rom_data: ROM_BUS_DI=%h, required %h", ROM_BUS_DI, ev);
          end
        end
      end
      if (RAM_BUS_RDY) begin
        ram_rdy_cnt++;
        checks++;
        if (prev_ram) begin
          errors++;
          $display("FAIL ram_rdy_width: RAM_BUS_RDY high 2 cycles, required 1");
        end else if (q_ram.size() == 0) begin
          errors++;
          $display("FAIL ram_rdy: unexpected RAM_BUS_RDY, DI=%h", RAM_BUS_DI);
        end else begin
          ev = q_ram.pop_front();
          if (RAM_BUS_DI !== ev) begin
            errors++;
            $display("FAIL ram_data: RAM_BUS_DI=%h, required %h", RAM_BUS_DI, ev);
          end
        end
      end
      prev_rom = ROM_BUS_RDY;
      prev_ram = RAM_BUS_RDY;
    end
  end

  task automatic pulse_rom(input logic [23:0] a);
    @(posedge clkin); #1;
    ROM_BUS_ADDR = a;
    ROM_BUS_RRQ  = 1'b1;
    @(posedge clkin); #1;
    ROM_BUS_RRQ  = 1'b0;
  endtask

  task automatic pulse_ram(input logic [23:0] a, input logic rd, input logic wr, input logic [7:0] d);
    @(posedge clkin); #1;
    RAM_BUS_ADDR = a;
    RAM_BUS_DO   = d;
    RAM_BUS_RRQ  = rd;
    RAM_BUS_WRQ  = wr;
    @(posedge clkin); #1;
    RAM_BUS_RRQ  = 1'b0;
    RAM_BUS_WRQ  = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clkin);
      if (q_mem.size() == 0 && q_rom.size() == 0 && q_ram.size() == 0 &&
          !MEM_RD && !MEM_WR && !ROM_BUS_RDY && !RAM_BUS_RDY) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clkin);
  endtask

  task automatic apply_reset();
    @(negedge clkin);
    nrst = 1'b0;
    repeat (2) @(negedge clkin);
    nrst = 1'b1;
    ram_di_model = 8'h00;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clkin);
    checks++;
    if ({MEM_RD, MEM_WR, ROM_BUS_RDY, RAM_BUS_RDY, bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd/wr/romrdy/ramrdy/err=%b, required 00000",
               {MEM_RD, MEM_WR, ROM_BUS_RDY, RAM_BUS_RDY, bus_err});
    end
    checks++;
    if (MEM_ADDR !== 24'h0 || MEM_DO !== 8'h0) begin
      errors++;
      $display("FAIL reset_mem: MEM_ADDR=%h MEM_DO=%h, required 0", MEM_ADDR, MEM_DO);
    end
    checks++;
    if (ROM_BUS_DI !== 8'h0 || RAM_BUS_DI !== 8'h0) begin
      errors++;
      $display("FAIL reset_di: ROM_BUS_DI=%h RAM_BUS_DI=%h, required 0", ROM_BUS_DI, RAM_BUS_DI);
    end
    nrst = 1'b1;
    repeat (2) @(negedge clkin);
  endtask

  task automatic test_rom_read();
    int c0;
    bit ok;
    ron = 1'b1;
    ack_dly = 2;
    c0 = rom_rdy_cnt;
    exp_rom(24'h012345);
    pulse_rom(24'h012345);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rom_read_done: not drained, required drained"); end
    checks++;
    if (rom_rdy_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL rom_read_rdy: %0d RDY pulses, required 1", rom_rdy_cnt - c0);
    end
    checks++;
    if (ROM_BUS_DI !== 8'hA5) begin
      errors++;
      $display("FAIL rom_read_di: ROM_BUS_DI=%h, required a5", ROM_BUS_DI);
    end
    ack_dly = 0;
  endtask

  task automatic test_latency();
    @(posedge clkin); #1;
    exp_rom(24'hFF0003);
    ROM_BUS_ADDR = 24'hFF0003;
    ROM_BUS_RRQ  = 1'b1;
    @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b0) begin errors++; $display("FAIL lat_n: MEM_RD=%b, required 0", MEM_RD); end
    @(posedge clkin); #1;
    ROM_BUS_RRQ = 1'b0;
    @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b1 || MEM_ADDR !== 24'h1F0003) begin
      errors++;
      $display("FAIL lat_n1: MEM_RD=%b MEM_ADDR=%h, required 1 1f0003", MEM_RD, MEM_ADDR);
    end
    @(negedge clkin);
    checks++;
    if (ROM_BUS_RDY !== 1'b1 || MEM_RD !== 1'b0) begin
      errors++;
      $display("FAIL lat_n2: RDY=%b MEM_RD=%b, required 1 0", ROM_BUS_RDY, MEM_RD);
    end
    @(negedge clkin);
    checks++;
    if (ROM_BUS_RDY !== 1'b0) begin errors++; $display("FAIL lat_n3: RDY=%b, required 0", ROM_BUS_RDY); end
  endtask

  task automatic test_ram_write();
    int c0;
    bit ok;
    ran = 1'b1;
    exp_ram(24'h020123, 1'b0, 8'h00);
    pulse_ram(24'h020123, 1'b1, 1'b0, 8'h00);
    wait_drain(ok);
    checks++;
    if (RAM_BUS_DI !== 8'hC3) begin
      errors++;
      $display("FAIL ram_read_di: RAM_BUS_DI=%h, required c3", RAM_BUS_DI);
    end
    c0 = ram_rdy_cnt;
    exp_ram(24'h000010, 1'b1, 8'h3C);
    pulse_ram(24'h000010, 1'b0, 1'b1, 8'h3C);
    wait_drain(ok);
    checks++;
    if (!ok || ram_rdy_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL ram_write_rdy: drained=%b pulses=%0d, required 1 1", ok, ram_rdy_cnt - c0);
    end
    checks++;
    if (RAM_BUS_DI !== 8'hC3) begin
      errors++;
      $display("FAIL ram_write_di: RAM_BUS_DI=%h, required c3 unchanged", RAM_BUS_DI);
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    apply_reset();
    ron = 1'b1;
    ran = 1'b1;
    for (int r = 0; r < 2; r++) begin
      logic [23:0] ra;
      logic [23:0] ma;
      ra = (r == 0) ? 24'h000031 : 24'h000041;
      ma = (r == 0) ? 24'h000032 : 24'h000042;
      if (r == 0) begin
        exp_ram(ma, 1'b0, 8'h00);
        exp_rom(ra);
      end else begin
        exp_rom(ra);
        exp_ram(ma, 1'b0, 8'h00);
      end
      @(posedge clkin); #1;
      ROM_BUS_ADDR = ra;
      RAM_BUS_ADDR = ma;
      ROM_BUS_RRQ  = 1'b1;
      RAM_BUS_RRQ  = 1'b1;
      @(posedge clkin); #1;
      ROM_BUS_RRQ  = 1'b0;
      RAM_BUS_RRQ  = 1'b0;
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL arb_round%0d: not drained, required drained", r); end
    end
  endtask

  task automatic test_ownership();
    bit ok;
    ron = 1'b0;
    exp_rom(24'h000088);
    pulse_rom(24'h000088);
    for (int i = 0; i < 10; i++) begin
      @(negedge clkin);
      checks++;
      if (MEM_RD !== 1'b0) begin errors++; $display("FAIL own_hold%0d: MEM_RD=%b, required 0", i, MEM_RD); end
    end
    @(posedge clkin); #1;
    ron = 1'b1;
    @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b0) begin errors++; $display("FAIL own_m: MEM_RD=%b, required 0", MEM_RD); end
    @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b1) begin errors++; $display("FAIL own_m1: MEM_RD=%b, required 1", MEM_RD); end
    wait_drain(ok);
    ack_dly = 3;
    ran = 1'b1;
    exp_ram(24'h000066, 1'b0, 8'h00);
    pulse_ram(24'h000066, 1'b1, 1'b0, 8'h00);
    ran = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL own_drop: in-flight access not completed, required completed"); end
    ran = 1'b1;
    ack_dly = 0;
  endtask

  task automatic test_overwrite();
    bit ok;
    ron = 1'b0;
    exp_rom(24'h0002AB);
    pulse_rom(24'h000100);
    pulse_rom(24'h0002AB);
    @(posedge clkin); #1;
    ron = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || ROM_BUS_DI !== 8'h4B) begin
      errors++;
      $display("FAIL overwrite: drained=%b DI=%h, required 1 4b", ok, ROM_BUS_DI);
    end
    exp_ram(24'h000055, 1'b1, 8'h77);
    pulse_ram(24'h000055, 1'b1, 1'b1, 8'h77);
    wait_drain(ok);
    ack_dly = 4;
    exp_rom(24'h000011);
    exp_rom(24'h000022);
    pulse_rom(24'h000011);
    pulse_rom(24'h000022);
    wait_drain(ok);
    checks++;
    if (!ok || ROM_BUS_DI !== 8'hC2) begin
      errors++;
      $display("FAIL inflight_queue: drained=%b DI=%h, required 1 c2", ok, ROM_BUS_DI);
    end
    ack_dly = 0;
  endtask

  task automatic test_reset_mid();
    int  c0;
    bit  ok;
    ack_en = 1'b0;
    ron    = 1'b1;
    q_mem.push_back({1'b0, 24'h000077, 8'h00});
    pulse_rom(24'h000077);
    @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b1) begin errors++; $display("FAIL rstmid_pre: MEM_RD=%b, required 1", MEM_RD); end
    c0 = rom_rdy_cnt;
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (MEM_RD !== 1'b0 || MEM_WR !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: MEM_RD=%b MEM_WR=%b, required 0 0", MEM_RD, MEM_WR);
    end
    repeat (2) @(negedge clkin);
    nrst = 1'b1;
    ram_di_model = 8'h00;
    ack_en = 1'b1;
    repeat (10) @(negedge clkin);
    checks++;
    if (rom_rdy_cnt !== c0 || MEM_RD !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nordy: rdy pulses=%0d MEM_RD=%b, required 0 0", rom_rdy_cnt - c0, MEM_RD);
    end
    exp_rom(24'h000099);
    pulse_rom(24'h000099);
    @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b1) begin errors++; $display("FAIL rstmid_idle: MEM_RD=%b, required 1", MEM_RD); end
    wait_drain(ok);
  endtask

`ifdef GSU_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    ack_en = 1'b0;
    ran    = 1'b1;
    q_mem.push_back({1'b0, 24'hE00099, 8'h00});
    q_ram.push_back(8'hFF);
    pulse_ram(24'h000099, 1'b1, 1'b0, 8'h00);
    n = 0;
    while (n < 400 && !RAM_BUS_RDY) begin
      @(negedge clkin);
      n++;
    end
    checks++;
    if (n != 256) begin errors++; $display("FAIL timeout_cycles: RDY after %0d, required 256", n); end
    checks++;
    if (bus_err !== 1'b1 || RAM_BUS_DI !== 8'hFF) begin
      errors++;
      $display("FAIL timeout_err: bus_err=%b DI=%h, required 1 ff", bus_err, RAM_BUS_DI);
    end
    repeat (3) @(negedge clkin);
    ack_en = 1'b1;
  endtask
`else
  task automatic test_timeout();
    int c0;
    ack_en = 1'b0;
    ran    = 1'b1;
    c0     = ram_rdy_cnt;
    q_mem.push_back({1'b0, 24'hE00099, 8'h00});
    pulse_ram(24'h000099, 1'b1, 1'b0, 8'h00);
    repeat (300) @(negedge clkin);
    checks++;
    if (MEM_RD !== 1'b1 || bus_err !== 1'b0 || ram_rdy_cnt !== c0) begin
      errors++;
      $display("FAIL no_timeout: MEM_RD=%b bus_err=%b rdy=%0d, required 1 0 0",
               MEM_RD, bus_err, ram_rdy_cnt - c0);
    end
    apply_reset();
    ack_en = 1'b1;
  endtask
`endif

  initial begin
    nrst         = 1'b0;
    ROM_BUS_ADDR = 24'h0;
    ROM_BUS_RRQ  = 1'b0;
    RAM_BUS_ADDR = 24'h0;
    RAM_BUS_RRQ  = 1'b0;
    RAM_BUS_WRQ  = 1'b0;
    RAM_BUS_DO   = 8'h0;
    ron          = 1'b0;
    ran          = 1'b0;
    test_reset();
    test_rom_read();
    test_latency();
    test_ram_write();
    test_arbitration();
    test_ownership();
    test_overwrite();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsu_bus_responder.md
GSU_BUS_RESPONDER -- requirements
Module: gsu_bus_responder

Interface
REQ-001 Parameter RAM_BASE, default 24'hE00000: memory-side base address of Game Pak RAM.
REQ-002 Parameter RAM_MASK, default 24'h01FFFF: mask applied to RAM_BUS_ADDR before RAM_BASE is added.
REQ-003 Parameter ROM_MASK, default 24'h1FFFFF: mask applied to ROM_BUS_ADDR; the ROM base is 0.
REQ-004 clkin  in  1  sole clock; all logic is rising-edge.
REQ-005 nrst  in  1  asynchronous, active-low reset.
REQ-006 ROM_BUS_ADDR  in  24  GSU ROM read address; ROM_BUS_RRQ  in  1  one-cycle read request pulse.
REQ-007 ROM_BUS_DI  out  8  ROM read data; ROM_BUS_RDY  out  1  one-cycle completion pulse.
REQ-008 RAM_BUS_ADDR  in  24  GSU RAM address; RAM_BUS_RRQ  in  1  read pulse; RAM_BUS_WRQ  in  1  write pulse; RAM_BUS_DO  in  8  write data.
REQ-009 RAM_BUS_DI  out  8  RAM read data; RAM_BUS_RDY  out  1  one-cycle completion pulse, for reads and writes.
REQ-010 ron  in  1  GSU owns ROM; ran  in  1  GSU owns RAM.
REQ-011 MEM_ADDR  out  24, MEM_DO  out  8, MEM_RD  out  1, MEM_WR  out  1, MEM_DI  in  8, MEM_ACK  in  1: shared external memory port.
REQ-012 bus_err  out  1  sticky timeout flag.

Function
REQ-013 A request pulse SHALL latch its address, its type and, for writes, its data into a one-deep pending slot per port (ROM, RAM).
REQ-014 A new pulse on a port whose slot is pending but not yet issued SHALL overwrite that slot.
REQ-015 A new pulse on a port whose request is in flight SHALL be stored in the slot and serviced after the current request completes.
REQ-016 If RAM_BUS_RRQ and RAM_BUS_WRQ arrive in the same cycle, the write SHALL win and the read SHALL be dropped.
REQ-017 FSM states: IDLE, ROM_ACC, RAM_ACC, DONE.
REQ-018 IDLE -> ROM_ACC when the ROM slot is pending and ron=1.
REQ-019 IDLE -> RAM_ACC when the RAM slot is pending and ran=1.
REQ-020 When both ports are eligible, arbitration SHALL be round-robin: the port not served last wins. The RAM port wins the first contention after reset.
REQ-021 A pending request whose ownership bit is 0 SHALL stay pending and SHALL NOT be issued.
REQ-022 In ROM_ACC, MEM_RD=1 and MEM_ADDR=ROM_BUS_ADDR&ROM_MASK.
REQ-023 In RAM_ACC, MEM_RD or MEM_WR=1 and MEM_ADDR=RAM_BASE+(RAM_BUS_ADDR&RAM_MASK); MEM_DO carries the write data.
REQ-024 MEM_RD/MEM_WR SHALL stay asserted until the cycle MEM_ACK=1 is sampled.
REQ-025 On MEM_ACK the FSM SHALL go to DONE and capture MEM_DI into the served port's DI register (reads only).
REQ-026 In DONE the served port's RDY SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-027 DI registers SHALL hold their value until the next read completes on the same port.
REQ-028 Minimum latency is 3 cycles: pulse at cycle N, MEM_RD at N+1, MEM_ACK at N+1, RDY at N+2. There SHALL be one IDLE cycle between consecutive accesses.
REQ-029 Ownership dropping while a request is in flight SHALL NOT abort that access.
REQ-030 MEM_RD and MEM_WR SHALL never both be 1.

Reset
REQ-031 While nrst=0: FSM=IDLE; all slots cleared; MEM_RD, MEM_WR, ROM_BUS_RDY, RAM_BUS_RDY and bus_err=0; MEM_ADDR, MEM_DO, ROM_BUS_DI and RAM_BUS_DI=0; round-robin pointer set to favour RAM.
REQ-032 A reset asserted mid-access SHALL drop MEM_RD/MEM_WR immediately, without waiting for a clock edge. The interrupted request SHALL be lost and no RDY SHALL be issued for it.

Configuration
REQ-033 Macro GSU_BUS_TIMEOUT_EN, when defined: an 8-bit counter runs in ROM_ACC/RAM_ACC. After 255 cycles without MEM_ACK the access SHALL be dropped, read data forced to 8'hFF, bus_err set (sticky until reset), and DONE entered normally.
REQ-034 Without GSU_BUS_TIMEOUT_EN, no counter SHALL exist, accesses SHALL wait indefinitely, and bus_err SHALL be tied to 0.

Structure
REQ-035 A shared package gsu_pkg SHALL hold the FSM state encoding, the default RAM_BASE/RAM_MASK/ROM_MASK constants and the timeout limit 8'd255.
REQ-036 One sub-module, gsu_bus_slot, SHALL be instantiated twice (ROM, RAM) and implement the pending/in-flight slot latching of REQ-013..REQ-016.

Verification
REQ-037 ron=1, ROM_BUS_RRQ with address 24'h012345, MEM_ACK after 2 cycles with MEM_DI=8'hA5 -> MEM_ADDR=24'h012345, one ROM_BUS_RDY pulse, ROM_BUS_DI=8'hA5.
REQ-038 ran=1, RAM_BUS_WRQ with address 24'h000010, data 8'h3C -> MEM_WR=1, MEM_ADDR=24'hE00010, MEM_DO=8'h3C, one RAM_BUS_RDY pulse, RAM_BUS_DI unchanged.
REQ-039 ROM and RAM reads pulsed in the same cycle, then again -> RAM served first, then ROM; in the second round ROM first, then RAM.
REQ-040 ron=0, ROM read pulsed, ron raised 10 cycles later -> no MEM_RD while ron=0; the access issues the cycle after ron=1.
REQ-041 nrst pulled low with MEM_RD=1 -> MEM_RD=0 with no clock edge; after release no RDY is issued and the FSM is in IDLE.
REQ-042 With GSU_BUS_TIMEOUT_EN, MEM_ACK held at 0 -> after 255 cycles the served RDY pulses, data=8'hFF, bus_err=1.
